// File: rtl/busy_goto_pkg.sv
// Shared types and constants for the busy-counting grant controller.
package busy_goto_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        GRANT     = 2'd2
    } gnt_state_e;

    localparam int DEF_BUSY_CNT = 3;
    localparam int DEF_TIMEOUT  = 64;
    localparam int DEF_MAX_PEND = 4;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/busy_goto_grant_ctrl_pend_counter.sv
// Saturating up/down count of queued requests; a push into a full queue is
// dropped and reported with a registered one-cycle overflow pulse.
module pend_counter
    import busy_goto_pkg::*;
#(
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             inc,
    input  logic                             dec,
    output logic [cnt_width(MAX_PEND)-1:0]   cnt,
    output logic                             ovf
);

    localparam int PW = cnt_width(MAX_PEND);
    localparam logic [PW-1:0] CNT_MAX = PW'(MAX_PEND);

    logic          full;
    logic [PW-1:0] cnt_next;
    logic          ovf_next;

    assign full = (cnt == CNT_MAX);

    // Next count; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_next = cnt;
        ovf_next = 1'b0;
        if (inc && !dec) begin
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt + PW'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != {PW{1'b0}}) begin
                cnt_next = cnt - PW'(1);
            end else begin
                cnt_next = cnt;
            end
        end else begin
            cnt_next = cnt;
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {PW{1'b0}};
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: rtl/busy_goto_grant_ctrl.sv
// Grant controller: per request, waits for BUSY_CNT sampled busy cycles then
// pulses gnt; queues overlapping requests and aborts if busy stalls too long.
module busy_goto_grant_ctrl
    import busy_goto_pkg::*;
#(
    parameter int BUSY_CNT = DEF_BUSY_CNT,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req,
    input  logic                             busy,
    output logic                             gnt,
    output logic                             active,
    output logic [cnt_width(MAX_PEND)-1:0]   pend_cnt,
    output logic                             timeout_err,
    output logic                             ovf_err
);

    localparam int BW = cnt_width(BUSY_CNT);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int PW = cnt_width(MAX_PEND);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BUSY_CNT - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_MAX   = TW'(TIMEOUT);

    gnt_state_e    state_r, state_next;
    logic [BW-1:0] bcnt_r, bcnt_next;
    logic [TW-1:0] timer_r, timer_next;
    logic          gnt_next, tmo_next;
    logic          enq, deq, pend_any;

    assign pend_any = (pend_cnt != {PW{1'b0}});
    assign enq      = req && (state_r != IDLE);

    // Next state, counters and pulse outputs.
    always_comb begin
        state_next = state_r;
        bcnt_next  = bcnt_r;
        timer_next = timer_r;
        gnt_next   = 1'b0;
        tmo_next   = 1'b0;
        deq        = 1'b0;
        case (state_r)
            IDLE: begin
                bcnt_next  = {BW{1'b0}};
                timer_next = {TW{1'b0}};
                if (req) begin
                    state_next = WAIT_BUSY;
                end else if (pend_any) begin
                    // A request queued on the final GRANT edge still gets served.
                    state_next = WAIT_BUSY;
                    deq        = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    timer_next = {TW{1'b0}};
                    if (bcnt_r == BCNT_LAST) begin
                        state_next = GRANT;
                        gnt_next   = 1'b1;
                        bcnt_next  = {BW{1'b0}};
                    end else begin
                        bcnt_next  = bcnt_r + BW'(1);
                    end
                end else if (timer_r == TMR_LAST) begin
                    tmo_next   = 1'b1;
                    bcnt_next  = {BW{1'b0}};
                    timer_next = {TW{1'b0}};
                    if (pend_any) begin
                        state_next = WAIT_BUSY;
                        deq        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timer_r != TMR_MAX) begin
                    timer_next = timer_r + TW'(1);
                end else begin
                    timer_next = timer_r;
                end
            end
            GRANT: begin
                bcnt_next  = {BW{1'b0}};
                timer_next = {TW{1'b0}};
                if (pend_any) begin
                    state_next = WAIT_BUSY;
                    deq        = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                bcnt_next  = {BW{1'b0}};
                timer_next = {TW{1'b0}};
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            bcnt_r      <= {BW{1'b0}};
            timer_r     <= {TW{1'b0}};
            gnt         <= 1'b0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r     <= state_next;
            bcnt_r      <= bcnt_next;
            timer_r     <= timer_next;
            gnt         <= gnt_next;
            active      <= (state_next != IDLE);
            timeout_err <= tmo_next;
        end
    end

    pend_counter #(
        .MAX_PEND (MAX_PEND)
    ) u_pend (
        .clk (clk),
        .rst (rst),
        .inc (enq),
        .dec (deq),
        .cnt (pend_cnt),
        .ovf (ovf_err)
    );

endmodule

// File: tb/tb_busy_goto_grant_ctrl.sv
// Directed-vector bench: each table row drives one clock edge and lists the
// outputs expected just after that edge.
module tb_busy_goto_grant_ctrl;

    localparam int BUSY_CNT = 3;
    localparam int TIMEOUT  = 8;
    localparam int MAX_PEND = 2;

    logic       clk;
    logic       rst;
    logic       req;
    logic       busy;
    logic       gnt;
    logic       active;
    logic [1:0] pend_cnt;
    logic       timeout_err;
    logic       ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit rst, req, busy, gnt, act, tmo, ovf;
        int pend;
    } vec_t;

    vec_t tbl[$];

    busy_goto_grant_ctrl #(
        .BUSY_CNT (BUSY_CNT),
        .TIMEOUT  (TIMEOUT),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .busy        (busy),
        .gnt         (gnt),
        .active      (active),
        .pend_cnt    (pend_cnt),
        .timeout_err (timeout_err),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic v(input bit rs, input bit r, input bit b, input bit g,
                     input bit a, input bit t, input bit o, input int p);
        vec_t e;
        e.rst = rs; e.req = r; e.busy = b; e.gnt = g;
        e.act = a;  e.tmo = t; e.ovf = o;  e.pend = p;
        tbl.push_back(e);
    endtask

    task automatic run(input string name);
        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            busy = tbl[i].busy;
            @(posedge clk);
            #1;
            chk($sformatf("%s[e%0d].gnt", name, i + 1), int'(gnt), int'(tbl[i].gnt));
            chk($sformatf("%s[e%0d].active", name, i + 1), int'(active), int'(tbl[i].act));
            chk($sformatf("%s[e%0d].timeout_err", name, i + 1), int'(timeout_err), int'(tbl[i].tmo));
            chk($sformatf("%s[e%0d].ovf_err", name, i + 1), int'(ovf_err), int'(tbl[i].ovf));
            chk($sformatf("%s[e%0d].pend_cnt", name, i + 1), int'(pend_cnt), tbl[i].pend);
        end
        tbl.delete();
        rst  = 1'b0;
        req  = 1'b0;
        busy = 1'b0;
    endtask

    initial begin
        clk  = 1'b0;
        rst  = 1'b1;
        req  = 1'b0;
        busy = 1'b0;

        // Power-on reset, with req/busy high to show reset dominates.
        v(1,1,1, 0,0,0,0,0);
        v(1,0,0, 0,0,0,0,0);
        run("reset");

        // Nominal: req e2, busy e4/e6/e8 -> gnt seen after e8 only.
        v(0,0,0, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,0,1, 1,1,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("nominal");

        // Back-to-back busy e3/e4/e5.
        v(0,0,0, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 1,1,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("b2b");

        // Busy on the req edge is ignored: needs e3, e4 and one more (e6).
        v(0,0,0, 0,0,0,0,0);
        v(0,1,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,0,1, 1,1,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("req_edge_busy");

        // Timeout: one busy at e4, then eight quiet edges -> abort on e12.
        v(0,0,0, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        for (int k = 5; k <= 11; k++) v(0,0,0, 0,1,0,0,0);
        v(0,0,0, 0,0,1,0,0);
        v(0,0,0, 0,0,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("timeout");

        // Queueing: req e2/e5/e7, three grants in order, busy in GRANT ignored.
        v(0,0,0, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,0, 0,1,0,0,0);
        v(0,1,0, 0,1,0,0,1);
        v(0,0,0, 0,1,0,0,1);
        v(0,1,0, 0,1,0,0,2);
        v(0,0,1, 0,1,0,0,2);
        v(0,0,1, 1,1,0,0,2);
        v(0,0,1, 0,1,0,0,1);
        v(0,0,1, 0,1,0,0,1);
        v(0,0,1, 0,1,0,0,1);
        v(0,0,1, 1,1,0,0,1);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 1,1,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("queue");

        // Overflow: five reqs back to back, the last two dropped.
        v(0,1,0, 0,1,0,0,0);
        v(0,1,0, 0,1,0,0,1);
        v(0,1,0, 0,1,0,0,2);
        v(0,1,0, 0,1,0,1,2);
        v(0,1,0, 0,1,0,1,2);
        v(0,0,0, 0,1,0,0,2);
        run("overflow");

        // Reset mid-service, then stray busy, then a fresh full request.
        v(1,0,0, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,1,1, 0,1,0,0,1);
        v(0,0,1, 0,1,0,0,1);
        v(1,0,1, 0,0,0,0,0);
        v(0,0,1, 0,0,0,0,0);
        v(0,1,0, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 0,1,0,0,0);
        v(0,0,1, 1,1,0,0,0);
        v(0,0,0, 0,0,0,0,0);
        run("mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
